// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, forwarding-select encodings and the forwarding compare
// used by the MEM/WB stage and its forwarding unit.
package mem_wb_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // EX/MEM takes priority over MEM/WB; register zero never forwards.
  function automatic logic [1:0] fwd_select(
    input logic             mem_we,
    input logic [REG_W-1:0] mem_rd,
    input logic             wb_we,
    input logic [REG_W-1:0] wb_rd,
    input logic [REG_W-1:0] src
  );
    if (mem_we && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
      return FWD_MEM;
    end else if (wb_we && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
      return FWD_WB;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM inputs, forwarding sources and MEM/WB outputs of the memory stage.
// The slave side is the stage itself; the master side is the surrounding pipe.
interface mem_wb_stage_if
  import mem_wb_stage_pkg::*;
();

  logic [DATA_W-1:0] ALUResult_in;
  logic [REG_W-1:0]  WriteReg_in;
  logic [DATA_W-1:0] Write_data_in;
  logic              MemWrite_in;
  logic              MemRead_in;
  logic              MemToReg_in;
  logic              RegWrite_in;
  logic [REG_W-1:0]  ID_EX_rs;
  logic [REG_W-1:0]  ID_EX_rt;

  logic [DATA_W-1:0] MEM_data;
  logic [DATA_W-1:0] WB_data;
  logic [REG_W-1:0]  WriteReg_out;
  logic              RegWrite_out;
  logic [1:0]        Forward_ALU1;
  logic [1:0]        Forward_ALU2;
  logic              align_error;

  modport slave (
    input  ALUResult_in, WriteReg_in, Write_data_in, MemWrite_in, MemRead_in,
           MemToReg_in, RegWrite_in, ID_EX_rs, ID_EX_rt,
    output MEM_data, WB_data, WriteReg_out, RegWrite_out,
           Forward_ALU1, Forward_ALU2, align_error
  );

  modport master (
    output ALUResult_in, WriteReg_in, Write_data_in, MemWrite_in, MemRead_in,
           MemToReg_in, RegWrite_in, ID_EX_rs, ID_EX_rt,
    input  MEM_data, WB_data, WriteReg_out, RegWrite_out,
           Forward_ALU1, Forward_ALU2, align_error
  );

endinterface

// File: rtl/mem_wb_stage_forwarding_unit.sv
// Combinational forwarding selects for both ALU operands of the instruction in EX.
module forwarding_unit
  import mem_wb_stage_pkg::*;
(
  input  logic             mem_we_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             wb_we_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  output logic [1:0]       fwd_alu1_o,
  output logic [1:0]       fwd_alu2_o
);

  // Same priority rule applied independently to rs and rt.
  always_comb begin
    fwd_alu1_o = fwd_select(mem_we_i, mem_rd_i, wb_we_i, wb_rd_i, rs_i);
    fwd_alu2_o = fwd_select(mem_we_i, mem_rd_i, wb_we_i, wb_rd_i, rt_i);
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage: word-addressed data memory, MEM/WB pipeline register,
// register-file write-back data and forwarding outputs for the execute stage.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH = 256
)(
  input  logic           clock,
  input  logic           reset_n,
  mem_wb_stage_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     idx;
  logic              aligned;
  logic              mem_access;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] read_data_q,  read_data_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [REG_W-1:0]  write_reg_q,  write_reg_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              reg_write_q,  reg_write_d;
  logic              align_err_q,  align_err_d;

  // Upper address bits are dropped, so addresses alias modulo DEPTH words.
  assign idx        = bus.ALUResult_in[AW+1:2];
  assign aligned    = (bus.ALUResult_in[1:0] == 2'b00);
  assign mem_access = bus.MemRead_in | bus.MemWrite_in;
  assign rd_word    = mem_q[idx];

  // Store port; memory contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (bus.MemWrite_in && aligned) begin
      mem_q[idx] <= bus.Write_data_in;
    end
  end

  // Next MEM/WB contents; read data is the pre-store word when load and store coincide.
  always_comb begin
    read_data_d  = '0;
    alu_result_d = bus.ALUResult_in;
    write_reg_d  = bus.WriteReg_in;
    mem_to_reg_d = bus.MemToReg_in;
    reg_write_d  = bus.RegWrite_in;
    align_err_d  = align_err_q | (mem_access & ~aligned);
    if (bus.MemRead_in && aligned) begin
      read_data_d = rd_word;
    end
  end

  // MEM/WB pipeline register and sticky alignment flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= REG_ZERO;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      align_err_q  <= align_err_d;
    end
  end

  assign bus.MEM_data     = bus.ALUResult_in;
  assign bus.WB_data      = mem_to_reg_q ? read_data_q : alu_result_q;
  assign bus.WriteReg_out = write_reg_q;
  assign bus.RegWrite_out = reg_write_q;
  assign bus.align_error  = align_err_q;

  forwarding_unit u_fwd (
    .mem_we_i   (bus.RegWrite_in),
    .mem_rd_i   (bus.WriteReg_in),
    .wb_we_i    (reg_write_q),
    .wb_rd_i    (write_reg_q),
    .rs_i       (bus.ID_EX_rs),
    .rt_i       (bus.ID_EX_rt),
    .fwd_alu1_o (bus.Forward_ALU1),
    .fwd_alu2_o (bus.Forward_ALU2)
  );

endmodule
